cdc_req_ack_src: RTL

Source-side controller for a 4-phase request/acknowledge transfer of a data word into an unrelated clock domain. It accepts a word from a local valid/ready interface and holds it stable on a launch register. It drives the request line and waits for the returned acknowledge through an internal multi-flop synchronizer chain. It then releases the request and signals completion. It sits at every clock-domain boundary where a multi-bit bus must cross with guaranteed stability.

---
 rtl/cdc_req_ack_src_if.sv | 38 +++
 rtl/cdc_req_ack_src.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cdc_req_ack_src_if.sv
// Local valid/ready word interface plus the cross-domain req/ack/data bundle
// of the request/acknowledge source controller.
interface cdc_req_ack_src_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic                  o_xfer_req;
  logic [DATA_WIDTH-1:0] o_xfer_data;
  logic                  i_async_ack;
  logic                  o_done;
  logic                  o_timeout;

  // Controller side.
  modport master (
    input  i_valid,
    input  i_data,
    input  i_async_ack,
    output o_ready,
    output o_xfer_req,
    output o_xfer_data,
    output o_done,
    output o_timeout
  );

  // Producer / peer side.
  modport slave (
    output i_valid,
    output i_data,
    output i_async_ack,
    input  o_ready,
    input  o_xfer_req,
    input  o_xfer_data,
    input  o_done,
    input  o_timeout
  );
endinterface

// File: rtl/cdc_req_ack_src.sv
// Source side of a 4-phase req/ack crossing: launches a held data word, waits for the
// synchronized acknowledge to rise and fall, then pulses done. Per-phase watchdog is sticky.
module cdc_req_ack_src #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SYNC_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  cdc_req_ack_src_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRelease
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_DEPTH-1:0] ack_sync_q;
  logic                  ack_s;

  logic                  ready;
  logic                  accept;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  // Acknowledge synchronizer; nothing downstream looks at the raw async input.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_DEPTH-2:0], bus.i_async_ack};
    end
  end

  assign ack_s = ack_sync_q[SYNC_DEPTH-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_valid && !ack_s) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (ack_s) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!ack_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: ready is combinational, everything leaving the block is registered.
  always_comb begin
    ready  = (state_q == StIdle) && !ack_s;
    accept = ready && bus.i_valid;
    req_d  = (state_d == StReq);
    done_d = (state_q == StRelease) && (state_d == StIdle);
    data_d = accept ? bus.i_data : data_q;
  end

  // Per-phase watchdog; flags only, never disturbs the handshake.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (TIMEOUT_CYCLES != 0) begin
      if ((state_q == StIdle) || (state_d != state_q)) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_d == CntMax) begin
          timeout_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      done_q    <= done_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_xfer_req  = req_q;
  assign bus.o_xfer_data = data_q;
  assign bus.o_done      = done_q;
  assign bus.o_timeout   = timeout_q;

endmodule
